// File: rtl/pipe_skid_stage.sv
// pipe_skid_stage: elastic pipeline register with a 2-entry skid buffer.
// Carries a DATA_W payload between MIPS32 pipeline stages under valid/ready,
// injects a bubble on flush and counts downstream stall cycles.
//
// Handshake: a beat moves across a port on a rising edge where valid and
// ready are both 1. A producer holds valid and data steady until that edge;
// in_ready is a function of registered state and flush only (never of
// out_ready), and out_valid/out_data come straight from registers.
module pipe_skid_stage #(
  parameter int                 DATA_W = 64,
  parameter logic [DATA_W-1:0]  BUBBLE = {DATA_W{1'b0}},
  parameter int                 CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  // State encoding equals the number of held entries, so occupancy doubles
  // as the externally visible state of the controller.
  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_t;

  state_t             r_state;
  logic [DATA_W-1:0]  r_main;
  logic [DATA_W-1:0]  r_skid;
  logic [CNT_W-1:0]   r_stall_cnt;

  state_t             w_state_nxt;
  logic [DATA_W-1:0]  w_main_nxt;
  logic [DATA_W-1:0]  w_skid_nxt;
  logic               w_main_valid;
  logic               w_skid_valid;
  logic               w_in_fire;
  logic               w_out_fire;
  logic               w_stall;

  assign w_main_valid = (r_state != S_EMPTY);
  assign w_skid_valid = (r_state == S_TWO);

  assign in_ready   = ~w_skid_valid & ~flush;
  assign out_valid  = w_main_valid;
  assign out_data   = r_main;
  assign occupancy  = {1'b0, w_main_valid} + {1'b0, w_skid_valid};
  assign stall_cnt  = r_stall_cnt;

  assign w_in_fire  = in_valid & in_ready;
  assign w_out_fire = out_valid & out_ready;
  assign w_stall    = out_valid & ~out_ready;

  // Next-state and datapath selection; main is reloaded with BUBBLE on every
  // entry to EMPTY so out_data shows the NOP whenever out_valid is low.
  always_comb begin
    w_state_nxt = r_state;
    w_main_nxt  = r_main;
    w_skid_nxt  = r_skid;
    if (flush) begin
      w_state_nxt = S_EMPTY;
      w_main_nxt  = BUBBLE;
      w_skid_nxt  = BUBBLE;
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (w_in_fire) begin
            w_state_nxt = S_ONE;
            w_main_nxt  = in_data;
          end
        end
        S_ONE: begin
          if (w_in_fire && w_out_fire) begin
            w_main_nxt  = in_data;
          end else if (w_in_fire) begin
            w_state_nxt = S_TWO;
            w_skid_nxt  = in_data;
          end else if (w_out_fire) begin
            w_state_nxt = S_EMPTY;
            w_main_nxt  = BUBBLE;
          end
        end
        S_TWO: begin
          if (w_out_fire) begin
            w_state_nxt = S_ONE;
            w_main_nxt  = r_skid;
          end
        end
        default: begin
          w_state_nxt = S_EMPTY;
          w_main_nxt  = BUBBLE;
        end
      endcase
    end
  end

  // State and payload registers; reset empties the stage immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_EMPTY;
      r_main  <= BUBBLE;
      r_skid  <= BUBBLE;
    end else begin
      r_state <= w_state_nxt;
      r_main  <= w_main_nxt;
      r_skid  <= w_skid_nxt;
    end
  end

  // Saturating stall counter; only reset clears it, flush leaves it alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != {CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Directed bench for pipe_skid_stage plus a short scoreboarded random phase.
module tb_pipe_skid_stage;

  localparam int              DW     = 16;
  localparam int              CW     = 4;
  localparam logic [DW-1:0]   BUB    = 16'hDEAD;

  logic           clk;
  logic           rst_n;
  logic           flush;
  logic           in_valid;
  logic           in_ready;
  logic [DW-1:0]  in_data;
  logic           out_valid;
  logic           out_ready;
  logic [DW-1:0]  out_data;
  logic [1:0]     occupancy;
  logic [CW-1:0]  stall_cnt;

  int checks;
  int errors;

  logic [DW-1:0] exp_q[$];

  pipe_skid_stage #(
    .DATA_W (DW),
    .BUBBLE (BUB),
    .CNT_W  (CW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy),
    .stall_cnt (stall_cnt)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // drive one cycle of inputs, then advance to 1 time unit past the edge
  task automatic drive(input logic fl, input logic iv, input logic [DW-1:0] id, input logic ordy);
    flush     = fl;
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_empty(input string tag);
    chk({tag, "_ovalid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_odata"},  {16'd0, out_data},  {16'd0, BUB});
    chk({tag, "_occ"},    {30'd0, occupancy}, 32'd0);
  endtask

  initial begin
    logic           prev_hold;
    logic [DW-1:0]  prev_data;
    logic           r_fl, r_iv, r_or, m_ready, m_in_fire, m_out_fire;
    logic [DW-1:0]  r_d;
    int             beats;

    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    flush = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    out_ready = 1'b0;

    // ---- reset values
    repeat (2) @(posedge clk);
    #1;
    chk_empty("reset");
    chk("reset_stall", {28'd0, stall_cnt}, 32'd0);
    chk("reset_inrdy", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // ---- streaming 0x1..0x10
    for (int i = 1; i <= 16; i++) begin
      drive(1'b0, 1'b1, DW'(i), 1'b1);
      chk($sformatf("stream_data_%0d", i), {16'd0, out_data}, i);
      chk($sformatf("stream_occ_%0d", i), {30'd0, occupancy}, 32'd1);
    end
    drive(1'b0, 1'b0, '0, 1'b1);
    chk_empty("stream_drain");
    chk("stream_stall", {28'd0, stall_cnt}, 32'd0);

    // ---- back-pressure: A, B, C
    drive(1'b0, 1'b1, 16'h000A, 1'b1);
    chk("bp_a", {16'd0, out_data}, 32'h000A);
    drive(1'b0, 1'b1, 16'h000B, 1'b0);
    chk("bp_occ2", {30'd0, occupancy}, 32'd2);
    chk("bp_inrdy0", {31'd0, in_ready}, 32'd0);
    chk("bp_hold_a", {16'd0, out_data}, 32'h000A);
    drive(1'b0, 1'b1, 16'h000C, 1'b0);
    chk("bp_still2", {30'd0, occupancy}, 32'd2);
    chk("bp_hold_a2", {16'd0, out_data}, 32'h000A);
    drive(1'b0, 1'b1, 16'h000C, 1'b1);
    chk("bp_b", {16'd0, out_data}, 32'h000B);
    chk("bp_occ1", {30'd0, occupancy}, 32'd1);
    chk("bp_inrdy1", {31'd0, in_ready}, 32'd1);
    drive(1'b0, 1'b1, 16'h000C, 1'b1);
    chk("bp_c", {16'd0, out_data}, 32'h000C);
    chk("bp_occ_c", {30'd0, occupancy}, 32'd1);
    drive(1'b0, 1'b0, '0, 1'b1);
    chk_empty("bp_drain");
    chk("bp_stall", {28'd0, stall_cnt}, 32'd2);

    // ---- flush while TWO with a beat offered
    drive(1'b0, 1'b1, 16'h000E, 1'b0);
    drive(1'b0, 1'b1, 16'h000F, 1'b0);
    chk("fl_occ2", {30'd0, occupancy}, 32'd2);
    flush = 1'b1;
    in_valid = 1'b1;
    in_data = 16'h000D;
    #1;
    chk("fl_inrdy", {31'd0, in_ready}, 32'd0);
    drive(1'b1, 1'b1, 16'h000D, 1'b0);
    chk_empty("fl_after");
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, '0, 1'b1);
      chk($sformatf("fl_no_d_%0d", i), {31'd0, out_valid}, 32'd0);
    end
    chk("fl_stall", {28'd0, stall_cnt}, 32'd4);

    // ---- stall counter saturation
    drive(1'b0, 1'b1, 16'h0055, 1'b0);
    for (int i = 0; i < 20; i++) begin
      drive(1'b0, 1'b0, '0, 1'b0);
      if (i == 4) chk("sat_mid", {28'd0, stall_cnt}, 32'd9);
    end
    chk("sat_15", {28'd0, stall_cnt}, 32'd15);
    chk("sat_hold_data", {16'd0, out_data}, 32'h0055);
    drive(1'b1, 1'b0, '0, 1'b0);
    chk("sat_after_flush", {28'd0, stall_cnt}, 32'd15);
    chk_empty("sat_flush");

    // ---- asynchronous reset mid-clock while TWO
    drive(1'b0, 1'b1, 16'h0011, 1'b0);
    drive(1'b0, 1'b1, 16'h0022, 1'b0);
    chk("ar_occ2", {30'd0, occupancy}, 32'd2);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk_empty("ar_now");
    chk("ar_stall", {28'd0, stall_cnt}, 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("ar_inrdy", {31'd0, in_ready}, 32'd1);
    chk_empty("ar_release");

    // ---- random traffic against a scoreboard
    exp_q.delete();
    prev_hold = 1'b0;
    prev_data = '0;
    beats = 0;
    for (int cyc = 0; cyc < 4000 && beats < 1000; cyc++) begin
      r_fl = ($urandom_range(0, 99) < 3);
      r_iv = ($urandom_range(0, 99) < 70);
      r_or = ($urandom_range(0, 99) < 60);
      r_d  = DW'($urandom_range(0, 16'hFFFF));
      flush = r_fl;
      in_valid = r_iv;
      in_data = r_d;
      out_ready = r_or;
      #1;
      m_ready = (exp_q.size() < 2) && !r_fl;
      m_in_fire = r_iv && m_ready;
      m_out_fire = (exp_q.size() > 0) && r_or;
      chk("rnd_inrdy", {31'd0, in_ready}, {31'd0, m_ready});
      chk("rnd_occ", {30'd0, occupancy}, exp_q.size());
      chk("rnd_ovalid", {31'd0, out_valid}, {31'd0, exp_q.size() > 0});
      if (exp_q.size() == 0) chk("rnd_bubble", {16'd0, out_data}, {16'd0, BUB});
      if (prev_hold) chk("rnd_stable", {16'd0, out_data}, {16'd0, prev_data});
      if (m_out_fire) begin
        chk("rnd_data", {16'd0, out_data}, {16'd0, exp_q[0]});
        void'(exp_q.pop_front());
        beats++;
      end
      prev_hold = (exp_q.size() > 0) && !m_out_fire && !r_fl;
      prev_data = out_data;
      if (r_fl) exp_q.delete();
      else if (m_in_fire) exp_q.push_back(r_d);
      @(posedge clk);
      #1;
    end
    chk("rnd_beats_reached", (beats >= 1000) ? 32'd1 : 32'd0, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
